// File: rtl/sawtooth_pkg.sv
// Shared types for the sawtooth receiver: FSM state encoding and the
// per-cycle sample classification codes.
// Purely declarative; no logic, no latency, no flow control.
package sawtooth_pkg;

    // Lock-acquisition states of the receiver.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    // How the current sample relates to the previous one.
    typedef enum logic [1:0] {
        CLS_HOLD   = 2'd0,
        CLS_STEP   = 2'd1,
        CLS_WRAP   = 2'd2,
        CLS_GLITCH = 2'd3
    } cls_e;

endpackage

// File: rtl/sawtooth_rx_classify.sv
// Sample classifier: compares the new sample against the previous one.
// Latency 0 (purely combinational); no flow control.
// Ports: val (new sample), val_q (previous sample), primed (previous sample
// is meaningful), cls (HOLD/STEP/WRAP/GLITCH).
module sawtooth_rx_classify
    import sawtooth_pkg::*;
#(
    parameter int VAL_BITS = 7
) (
    input  logic [VAL_BITS-1:0] val,
    input  logic [VAL_BITS-1:0] val_q,
    input  logic                primed,
    output cls_e                cls
);

    localparam logic [VAL_BITS-1:0] VAL_MAX = '1;
    localparam logic [VAL_BITS-1:0] VAL_ONE = VAL_BITS'(1);

    logic                at_max;
    logic [VAL_BITS-1:0] val_inc;

    assign at_max  = (val_q == VAL_MAX);
    assign val_inc = val_q + VAL_ONE;

    always_comb begin
        cls = CLS_GLITCH;
        // Unprimed: val_q is the reset value, not a real sample, so treat
        // the cycle as neutral.
        if (!primed) begin
            cls = CLS_HOLD;
        end else if (val == val_q) begin
            cls = CLS_HOLD;
        end else if (!at_max && (val == val_inc)) begin
            cls = CLS_STEP;
        end else if (at_max && (val == '0)) begin
            cls = CLS_WRAP;
        end
    end

endmodule

// File: rtl/sawtooth_rx.sv
// Sawtooth receiver: detects wraps, measures and locks onto the period,
// flags glitches / period changes / timeouts. Latency 1 (all outputs
// registered); no backpressure, one sample accepted every clk.
// Ports: clk, rst (async active-low), val in; wrap, period, period_vld,
// locked, err out; err_cnt out only when SAWTOOTH_RX_ERR_CNT_EN is defined.
module sawtooth_rx
    import sawtooth_pkg::*;
#(
    parameter int VAL_BITS = 7,
    parameter int PER_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VAL_BITS-1:0] val,
    output logic                wrap,
    output logic [PER_BITS-1:0] period,
    output logic                period_vld,
    output logic                locked,
    output logic                err
`ifdef SAWTOOTH_RX_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    localparam logic [PER_BITS-1:0] CNT_MAX = '1;
    localparam logic [PER_BITS-1:0] CNT_ONE = PER_BITS'(1);

    state_e              state_q, state_d;
    logic [VAL_BITS-1:0] val_q, val_d;
    logic                primed_q, primed_d;
    logic [PER_BITS-1:0] cnt_q, cnt_d;
    logic [PER_BITS-1:0] period_q, period_d;
    logic                wrap_q, wrap_d;
    logic                period_vld_q, period_vld_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic                err_evt;
    logic                cnt_sat;
    cls_e                cls;

    sawtooth_rx_classify #(
        .VAL_BITS (VAL_BITS)
    ) u_classify (
        .val    (val),
        .val_q  (val_q),
        .primed (primed_q),
        .cls    (cls)
    );

    always_comb begin
        state_d      = state_q;
        val_d        = val;
        primed_d     = 1'b1;
        period_d     = period_q;
        wrap_d       = (cls == CLS_WRAP);
        period_vld_d = 1'b0;
        err_evt      = 1'b0;
        cnt_sat      = (cnt_q == CNT_MAX);

        // cnt holds cycles since the last wrap; it saturates so that a dead
        // source is reported as a timeout rather than silently rolling over.
        if (cls == CLS_WRAP) begin
            cnt_d = CNT_ONE;
        end else if (cnt_sat) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // Priority: GLITCH, then WRAP, then saturation.
        case (state_q)
            ST_SEARCH: begin
                if (cls == CLS_WRAP) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (cls == CLS_GLITCH) begin
                    state_d = ST_SEARCH;
                end else if (cls == CLS_WRAP) begin
                    state_d      = ST_LOCKED;
                    period_d     = cnt_q;
                    period_vld_d = 1'b1;
                end else if (cnt_sat) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (cls == CLS_GLITCH) begin
                    state_d = ST_SEARCH;
                    err_evt = 1'b1;
                end else if (cls == CLS_WRAP) begin
                    period_vld_d = 1'b1;
                    if (cnt_q != period_q) begin
                        // Period changed: report the new distance, drop lock.
                        state_d  = ST_SEARCH;
                        period_d = cnt_q;
                        err_evt  = 1'b1;
                    end
                end else if (cnt_sat) begin
                    state_d = ST_SEARCH;
                    err_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        err_d    = err_q | err_evt;
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_SEARCH;
            val_q        <= '0;
            primed_q     <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            wrap_q       <= 1'b0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            val_q        <= val_d;
            primed_q     <= primed_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            wrap_q       <= wrap_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign wrap       = wrap_q;
    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign locked     = locked_q;
    assign err        = err_q;

`ifdef SAWTOOTH_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sawtooth_rx.sv
// Bench for sawtooth_rx: randomized / directed sawtooth streams, a
// wrap-interval reference model feeding scoreboard queues, and a monitor
// that pops and compares whenever the DUT emits wrap, period_vld or a
// change of locked/err.
module tb_sawtooth_rx;

    localparam int  VMAX = 127;
    localparam int  CMAX = (1 << 24) - 1;

    typedef struct {
        int t;
        int period;
        bit locked;
        bit err;
    } pv_t;

    typedef struct {
        int t;
        bit locked;
        bit err;
    } st_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  val;
    logic        wrap;
    logic [23:0] period;
    logic        period_vld;
    logic        locked;
    logic        err;
    logic        wrap11;
    logic [10:0] period11;
    logic        period_vld11;
    logic        locked11;
    logic        err11;
`ifdef SAWTOOTH_RX_ERR_CNT_EN
    logic [7:0]  err_cnt;
    logic [7:0]  err_cnt11;
`endif

    sawtooth_rx #(.VAL_BITS(7), .PER_BITS(24)) u_dut (
`ifdef SAWTOOTH_RX_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .clk        (clk),
        .rst        (rst),
        .val        (val),
        .wrap       (wrap),
        .period     (period),
        .period_vld (period_vld),
        .locked     (locked),
        .err        (err)
    );

    // Short period counter instance, used for the timeout check.
    sawtooth_rx #(.VAL_BITS(7), .PER_BITS(11)) u_dut11 (
`ifdef SAWTOOTH_RX_ERR_CNT_EN
        .err_cnt    (err_cnt11),
`endif
        .clk        (clk),
        .rst        (rst),
        .val        (val),
        .wrap       (wrap11),
        .period     (period11),
        .period_vld (period_vld11),
        .locked     (locked11),
        .err        (err11)
    );

    always #5 clk = ~clk;

    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    pv_t exp_pv[$];
    int  exp_wrap[$];
    st_t exp_st[$];

    // Reference model: lock needs two consecutive clean wraps; a locked
    // receiver expects every wrap interval to equal the reference interval.
    int  m_prev;
    int  m_last_wrap;
    int  m_good;
    int  m_ref;
    bit  m_err;
    bit  m_locked;
    int  m_errcnt;

    int  src;
    int  src_bits;
    int  cur_val;
    int  last_wrap11;
    int  fall11;
    bit  locked11_prev;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: DUT output at cycle %0d, expected none", name, cyc);
    endtask

    task automatic m_reset();
        m_prev   = -1;
        m_good   = 0;
        m_ref    = 0;
        m_err    = 1'b0;
        m_locked = 1'b0;
        m_errcnt = 0;
        exp_pv.delete();
        exp_wrap.delete();
        exp_st.delete();
    endtask

    // Called when v is driven; its effect appears after edge t = cyc+1.
    task automatic model_step(input int v);
        int t;
        int cnt;
        bit lk_prev;
        bit er_prev;
        bit evt;
        bit is_wrap;
        bit is_step;
        t       = cyc + 1;
        lk_prev = m_locked;
        er_prev = m_err;
        evt     = 1'b0;
        if (m_prev < 0) begin
            m_prev      = v;
            m_last_wrap = t;
            return;
        end
        cnt = t - m_last_wrap;
        if (cnt > CMAX) cnt = CMAX;
        is_wrap = (m_prev == VMAX) && (v == 0);
        is_step = (m_prev != VMAX) && (v == m_prev + 1);
        if (!is_wrap && !is_step && (v != m_prev)) begin
            if (m_good >= 2) evt = 1'b1;
            m_good = 0;
        end else if (is_wrap) begin
            exp_wrap.push_back(t);
            if (m_good == 1) begin
                m_ref  = cnt;
                m_good = 2;
                exp_pv.push_back('{t: t, period: cnt, locked: 1'b1, err: m_err});
            end else if (m_good >= 2) begin
                if (cnt == m_ref) begin
                    exp_pv.push_back('{t: t, period: cnt, locked: 1'b1, err: m_err});
                end else begin
                    evt    = 1'b1;
                    m_ref  = cnt;
                    m_good = 0;
                    exp_pv.push_back('{t: t, period: cnt, locked: 1'b0, err: 1'b1});
                end
            end else begin
                m_good = 1;
            end
            m_last_wrap = t;
        end else if (cnt == CMAX) begin
            if (m_good >= 2) evt = 1'b1;
            m_good = 0;
        end
        if (evt) begin
            m_err = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
        end
        m_locked = (m_good >= 2);
        if ((m_locked != lk_prev) || (m_err != er_prev))
            exp_st.push_back('{t: t, locked: m_locked, err: m_err});
        m_prev = v;
    endtask

    task automatic drive_now(input int v);
        val     = 7'(v);
        cur_val = v;
        model_step(v);
    endtask

    task automatic step(input int v);
        @(negedge clk);
        drive_now(v);
    endtask

    task automatic ramp(input int n);
        repeat (n) begin
            src = (src + 1) % (1 << src_bits);
            step(src >> (src_bits - 7));
        end
    endtask

    task automatic ramp_until(input int target, input int limit);
        int k;
        k = 0;
        while ((cur_val != target) && (k < limit)) begin
            ramp(1);
            k++;
        end
    endtask

    task automatic set_bits(input int b);
        src_bits = b;
        src      = cur_val << (b - 7);
    endtask

    // Monitor / scoreboard.
    initial begin
        pv_t p;
        st_t s;
        int  e;
        bit [1:0] prev_st;
        prev_st       = 2'b00;
        last_wrap11   = 0;
        fall11        = -1;
        locked11_prev = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                if (wrap) begin
                    if (exp_wrap.size() == 0) miss("wrap_unexpected");
                    else begin
                        e = exp_wrap.pop_front();
                        chk("wrap_cycle", cyc, e);
                    end
                end
                if (period_vld) begin
                    if (exp_pv.size() == 0) miss("period_vld_unexpected");
                    else begin
                        p = exp_pv.pop_front();
                        chk("pv_cycle", cyc, p.t);
                        chk("pv_period", period, p.period);
                        chk("pv_locked", locked, p.locked);
                        chk("pv_err", err, p.err);
                    end
                end
                if ({locked, err} != prev_st) begin
                    if (exp_st.size() == 0) miss("status_change_unexpected");
                    else begin
                        s = exp_st.pop_front();
                        chk("st_cycle", cyc, s.t);
                        chk("st_locked", locked, s.locked);
                        chk("st_err", err, s.err);
                    end
                end
                prev_st = {locked, err};
            end else begin
                prev_st = 2'b00;
            end
            if (wrap11) last_wrap11 = cyc;
            if (locked11_prev && !locked11 && (fall11 < 0)) fall11 = cyc;
            locked11_prev = locked11;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not end, expected end before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int v;
        rst      = 1'b0;
        val      = '0;
        cur_val  = 0;
        src      = 0;
        src_bits = 10;
        m_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_wrap", wrap, 0);
        chk("rst_period", period, 0);
        chk("rst_period_vld", period_vld, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
`ifdef SAWTOOTH_RX_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b1;
        drive_now(0);

        // Clean 1024-cycle ramp, 11 periods.
        ramp(11 * 1024 + 16);
        chk("clean_locked", locked, 1);
        chk("clean_period", period, 1024);
        chk("clean_err", err, 0);

        // One-cycle glitch 40 -> 55 while locked.
        ramp_until(40, 2048);
        src = src + 1;
        step(55);
        @(posedge clk);
        #1;
        chk("glitch_locked", locked, 0);
        chk("glitch_err", err, 1);
`ifdef SAWTOOTH_RX_ERR_CNT_EN
        chk("glitch_err_cnt", err_cnt, 1);
`endif
        ramp(3 * 1024);
        chk("relock_locked", locked, 1);
        chk("relock_err", err, 1);

        // Switch to a 2048-cycle source at a wrap.
        ramp_until(0, 2048);
        set_bits(11);
        ramp(2050);
        chk("p2048_locked", locked, 0);
        chk("p2048_period", period, 2048);
        chk("p2048_err", err, 1);
        ramp(2 * 2048);
        chk("p2048_relock", locked, 1);

        // Random holds, steps and occasional glitches.
        repeat (3000) begin
            r = $urandom_range(0, 999);
            if (r < 3) v = $urandom_range(0, 127);
            else if (r < 300) v = cur_val;
            else v = (cur_val + 1) % 128;
            step(v);
        end

        // Asynchronous reset mid-ramp at val=64.
        set_bits(10);
        ramp(4 * 1024);
        ramp_until(64, 2048);
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_period", period, 1024);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        chk("arst_wrap", wrap, 0);
        chk("arst_period", period, 0);
        chk("arst_period_vld", period_vld, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", err, 0);
`ifdef SAWTOOTH_RX_ERR_CNT_EN
        chk("arst_err_cnt", err_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive_now(cur_val);
        ramp(3 * 1024);

        // Freeze at 90: short counter must time out 2047 cycles after wrap.
        ramp_until(90, 2048);
        chk("freeze_locked11_before", locked11, 1);
        chk("freeze_err11_before", err11, 0);
        fall11 = -1;
        repeat (2200) step(90);
        chk("timeout_distance", fall11 - last_wrap11, 2047);
        chk("timeout_err11", err11, 1);
        chk("freeze_main_locked", locked, 1);
        set_bits(10);
        ramp(100);

        // 300 glitches, each preceded by a fast relock at period 128.
        repeat (300) begin
            step(127);
            step(0);
            for (int i = 1; i <= 127; i++) step(i);
            step(0);
            step($urandom_range(2, 126));
        end
        repeat (4) step(cur_val);
        chk("burst_err", err, 1);
        chk("burst_locked", locked, 0);
`ifdef SAWTOOTH_RX_ERR_CNT_EN
        chk("burst_err_cnt_model", err_cnt, m_errcnt);
        chk("burst_err_cnt_sat", err_cnt, 255);
`endif

        @(posedge clk);
        #2;
        chk("left_pv", exp_pv.size(), 0);
        chk("left_wrap", exp_wrap.size(), 0);
        chk("left_status", exp_st.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
